cl_payload_unpack: RTL and testbench
====================================

# cl_payload_unpack

Drains one buffered AFU frame of 512-bit cache lines (CLs) from the frame FIFO and serializes each CL payload into a stream of soft-symbol tuples (STs) for the turbo decoder input. It sits directly downstream of the CL header-analysis stage. It starts when that stage raises `ff_rd_ready` and returns `ff_rd_finish` when the whole frame has been consumed. Frame length from `sb_len` drives start-of-packet (SOP) and end-of-packet (EOP) marking and the length check.

## Interface
- `CL`, 512: CL width in bits.
- `CL_HEAD`, 16: header width; header occupies bits [CL-1 : CL-CL_HEAD].
- `CL_PAYLOAD`, 496: payload width, bits [CL_PAYLOAD-1 : 0].
- `ST_W`, 16: width of one ST.
- `W_LEN`, 16: width of frame length in STs.

Ports:
- `clk` in 1: single clock.
- `rst_sync` in 1: synchronous, active-high reset.
- `ff_rd_ready` in 1: upstream has a complete frame in the FIFO; held high until `ff_rd_finish`.
- `sb_len` in W_LEN: frame length in STs; valid while `ff_rd_ready` is high.
- `ff_rd_empty` in 1: FIFO empty (show-ahead FIFO).
- `ff_rd_data` in CL: FIFO head word, valid when `!ff_rd_empty`.
- `ff_rd_ack` out 1: pops the FIFO head.
- `ff_rd_finish` out 1: one-cycle pulse, frame fully drained.
- `source_st` out ST_W: ST data.
- `source_valid` out 1: ST valid.
- `source_ready` in 1: downstream accepts.
- `source_sop` out 1: first ST of frame.
- `source_eop` out 1: ST number `frm_len` of frame.
- `frm_len` out W_LEN: latched frame length.
- `err_len` out 1: length-error pulse (see Configuration).

## Operation
- CL header fields:
  - bit CL-4 (508) is end-of-frame (EOF).
  - bits [CL-5 : CL-16] (507:496) give `n_st`, the number of valid STs in this CL.
- `ST_PER_CL = CL_PAYLOAD/ST_W = 31`. `n_st > 31` is clamped to 31.
- ST k of a CL is payload bits [CL_PAYLOAD-1-k*ST_W -: ST_W]; k=0 (MSB end) is emitted first.
- FSM states:
  - **IDLE:** when `ff_rd_ready` is high, latch `sb_len` into `frm_len`, clear `st_cnt`, go to LOAD.
  - **LOAD:** wait while `ff_rd_empty`. When not empty, pulse `ff_rd_ack` and capture `ff_rd_data` into the CL register.
    - If the clamped `n_st` is 0: go to FINISH if EOF is set, else stay in LOAD.
    - Otherwise go to EMIT.
  - **EMIT:** present ST k; advance k and `st_cnt` on `source_valid & source_ready`.
    - After the last ST of the CL, go to FINISH if EOF is set, else to LOAD.
  - **FINISH:** assert `ff_rd_finish` for exactly one cycle, then go to IDLE.
- `st_cnt` is W_LEN bits wide and saturates at all-ones.
- `source_sop` = valid & (`st_cnt`==0).
- `source_eop` = valid & (`st_cnt`+1 == `frm_len`).
- Excess STs (`st_cnt >= frm_len`) are consumed internally at one per cycle with `source_valid` low. They are never emitted.
- `frm_len`==0: no ST is ever emitted. CLs are still drained up to EOF, then `ff_rd_finish` is pulsed.
- Reset mid-frame: return to IDLE, clear the CL register and counters, no `ff_rd_finish`. The upstream stage shares `rst_sync`.

## Timing
- Reset values: `ff_rd_ack`=0, `ff_rd_finish`=0, `source_valid`=0, `source_sop`=0, `source_eop`=0, `source_st`=0, `frm_len`=0, `err_len`=0.
- `ff_rd_ready` sampled in IDLE at cycle t:
  - LOAD at t+1.
  - With FIFO non-empty, `ff_rd_ack` high at t+1.
  - First `source_valid` at t+2.
- One LOAD bubble cycle between consecutive CLs.
- Data, SOP and EOP hold stable while `source_valid & !source_ready`.
- `ff_rd_finish` is asserted one cycle after the last ST handshake, or after the LOAD of a zero-count EOF CL.
- The upstream stage drops `ff_rd_ready` one cycle after `ff_rd_finish`. IDLE is re-entered exactly then, so no stale re-trigger occurs.
- `ff_rd_ack` is never asserted while `ff_rd_empty` is high, and never outside LOAD.

## Configuration
- `CL_UNPACK_LEN_CHK_EN` defined: `err_len` pulses one cycle, coincident with `ff_rd_finish`, if any of the following occurred in the frame:
  - total header STs ≠ `frm_len`;
  - any `n_st` was clamped.
- Not defined: `err_len` is tied to 0 and the check logic is absent. Excess-ST suppression and clamping remain.

## Structure
- Package `cl_pkg` holds:
  - CL, CL_HEAD, CL_PAYLOAD and ST_W defaults;
  - `EOF_BIT`=CL-4;
  - `NST_HI`=CL-5 and `NST_LO`=CL-16;
  - `ST_PER_CL`;
  - the FSM state enum (IDLE, LOAD, EMIT, FINISH).
- Sub-module `cl_st_shifter` holds the CL register, the ST index k and the ST select mux. It is loaded in LOAD and advanced on handshake.

## Test plan
- Frame of one CL, EOF=1, `n_st`=5, `sb_len`=5, `source_ready`=1 → 5 STs, payload MSB slice first; SOP on ST0; EOP on ST4; `ff_rd_finish` one cycle later; `err_len`=0.
- Frame of 3 CLs with `n_st`=31, 31, 10 and EOF on CL3, `sb_len`=72 → 72 STs with one bubble between CLs; EOP on ST71; one `ack` per CL.
- Same stimulus with `source_ready` toggled 1/0 every cycle → identical ST sequence; outputs stable while stalled.
- `sb_len`=4, header STs totalling 6 → 4 STs emitted, EOP on ST3; `err_len` pulse with `ff_rd_finish` when the macro is defined, 0 otherwise.
- `n_st`=40, EOF=1, `sb_len`=31 → 31 STs emitted, `err_len`=1 (macro defined). Zero-count EOF CL after 10 STs with `sb_len`=10 → `finish` right after LOAD.
- `rst_sync` asserted mid-EMIT → all outputs 0 next cycle, no `finish`; a new frame afterwards unpacks correctly.

Source files
------------

// File: rtl/cl_payload_unpack_pkg.sv
// Shared constants, header field positions and FSM state type for the CL payload unpacker.
package cl_pkg;

    localparam int CL         = 512;
    localparam int CL_HEAD    = 16;
    localparam int CL_PAYLOAD = CL - CL_HEAD;
    localparam int ST_W       = 16;
    localparam int W_LEN      = 16;

    localparam int EOF_BIT    = CL - 4;
    localparam int NST_HI     = CL - 5;
    localparam int NST_LO     = CL - 16;
    localparam int NST_W      = NST_HI - NST_LO + 1;

    localparam int ST_PER_CL  = CL_PAYLOAD / ST_W;
    localparam int K_W        = $clog2(ST_PER_CL + 1);
    localparam int SH_W       = $clog2(CL_PAYLOAD);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT,
        FINISH
    } state_t;

    // A header count larger than the payload can physically hold is limited to a full CL.
    function automatic logic [K_W-1:0] clamp_nst(input logic [NST_W-1:0] n);
        if (n > NST_W'(ST_PER_CL)) begin
            return K_W'(ST_PER_CL);
        end
        return n[K_W-1:0];
    endfunction

    function automatic logic nst_over(input logic [NST_W-1:0] n);
        return n > NST_W'(ST_PER_CL);
    endfunction

endpackage

// File: rtl/cl_st_shifter.sv
// Holds the captured CL payload and walks its soft symbols MSB-first, one per advance.
module cl_st_shifter
    import cl_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_sync,
    input  logic                  i_load,
    input  logic                  i_adv,
    input  logic [CL_PAYLOAD-1:0] i_payload,
    input  logic                  i_eof,
    input  logic [K_W-1:0]        i_nst,
    output logic [ST_W-1:0]       o_st,
    output logic                  o_last,
    output logic                  o_eof
);

    logic [CL_PAYLOAD-1:0] r_payload;
    logic                  r_eof;
    logic [K_W-1:0]        r_nst;
    logic [K_W-1:0]        r_k;
    logic [SH_W-1:0]       w_base;

    always_ff @(posedge i_clk) begin
        if (i_rst_sync) begin
            r_payload <= '0;
            r_eof     <= 1'b0;
            r_nst     <= '0;
            r_k       <= '0;
        end else if (i_load) begin
            r_payload <= i_payload;
            r_eof     <= i_eof;
            r_nst     <= i_nst;
            r_k       <= '0;
        end else if (i_adv) begin
            r_k <= o_last ? '0 : r_k + K_W'(1);
        end
    end

    // Symbol k sits k symbol-widths below the top of the payload.
    assign w_base = SH_W'(CL_PAYLOAD - 1) - SH_W'(r_k) * SH_W'(ST_W);
    assign o_st   = r_payload[w_base -: ST_W];
    assign o_last = (r_k == r_nst - K_W'(1));
    assign o_eof  = r_eof;

endmodule

// File: rtl/cl_payload_unpack.sv
// Drains one frame of cache lines from the frame FIFO and streams their soft symbols.
// Optional length/clamp checking is enabled with `define CL_UNPACK_LEN_CHK_EN.
module cl_payload_unpack
    import cl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_sync,
    input  logic             ff_rd_ready,
    input  logic [W_LEN-1:0] sb_len,
    input  logic             ff_rd_empty,
    input  logic [CL-1:0]    ff_rd_data,
    output logic             ff_rd_ack,
    output logic             ff_rd_finish,
    output logic [ST_W-1:0]  source_st,
    output logic             source_valid,
    input  logic             source_ready,
    output logic             source_sop,
    output logic             source_eop,
    output logic [W_LEN-1:0] frm_len,
    output logic             err_len
);

    state_t           r_state;
    state_t           w_next;
    logic [W_LEN-1:0] r_frm_len;
    logic [W_LEN-1:0] r_st_cnt;
    logic             w_ack;
    logic             w_excess;
    logic             w_adv;
    logic             w_last;
    logic             w_eof;
    logic             w_start;
    logic [K_W-1:0]   w_nst_in;
    logic [ST_W-1:0]  w_st;
    logic             w_unused_hdr;

    // Header bits above EOF are reserved and carry nothing for this stage.
    assign w_unused_hdr = ^ff_rd_data[CL-1:EOF_BIT+1];

    assign w_nst_in = clamp_nst(ff_rd_data[NST_HI:NST_LO]);
    assign w_start  = (r_state == IDLE) && ff_rd_ready;
    assign w_ack    = (r_state == LOAD) && !ff_rd_empty;
    assign w_excess = (r_st_cnt >= r_frm_len);
    assign w_adv    = (r_state == EMIT) && (w_excess || source_ready);

    cl_st_shifter u_shifter (
        .i_clk      (clk),
        .i_rst_sync (rst_sync),
        .i_load     (w_ack),
        .i_adv      (w_adv),
        .i_payload  (ff_rd_data[CL_PAYLOAD-1:0]),
        .i_eof      (ff_rd_data[EOF_BIT]),
        .i_nst      (w_nst_in),
        .o_st       (w_st),
        .o_last     (w_last),
        .o_eof      (w_eof)
    );

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_state   <= IDLE;
            r_frm_len <= '0;
            r_st_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_frm_len <= sb_len;
                r_st_cnt  <= '0;
            end else if (w_adv && (r_st_cnt != '1)) begin
                r_st_cnt <= r_st_cnt + W_LEN'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (ff_rd_ready) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                // A zero-count CL is consumed in LOAD alone; only EOF ends the frame there.
                if (w_ack) begin
                    if (w_nst_in == '0) begin
                        if (ff_rd_data[EOF_BIT]) begin
                            w_next = FINISH;
                        end
                    end else begin
                        w_next = EMIT;
                    end
                end
            end
            EMIT: begin
                if (w_adv && w_last) begin
                    w_next = w_eof ? FINISH : LOAD;
                end
            end
            FINISH: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign ff_rd_ack    = w_ack;
    assign ff_rd_finish = (r_state == FINISH);
    assign source_valid = (r_state == EMIT) && !w_excess;
    assign source_st    = w_st;
    assign source_sop   = source_valid && (r_st_cnt == '0);
    assign source_eop   = source_valid && (({1'b0, r_st_cnt} + (W_LEN + 1)'(1)) == {1'b0, r_frm_len});
    assign frm_len      = r_frm_len;

`ifdef CL_UNPACK_LEN_CHK_EN
    logic [W_LEN:0] r_hdr_sum;
    logic           r_clamped;

    // The extra sum bit is sticky, so a runaway header total can never wrap back into range.
    always_ff @(posedge clk) begin
        if (rst_sync || w_start) begin
            r_hdr_sum <= '0;
            r_clamped <= 1'b0;
        end else if (w_ack) begin
            if (!r_hdr_sum[W_LEN]) begin
                r_hdr_sum <= r_hdr_sum + (W_LEN + 1)'(w_nst_in);
            end
            r_clamped <= r_clamped | nst_over(ff_rd_data[NST_HI:NST_LO]);
        end
    end

    assign err_len = ff_rd_finish && (r_clamped || (r_hdr_sum != {1'b0, r_frm_len}));
`else
    assign err_len = 1'b0;
`endif

endmodule

// File: tb/tb_cl_payload_unpack.sv
// Directed, table-driven bench for cl_payload_unpack with a show-ahead FIFO model.
`timescale 1ns/1ps
module tb_cl_payload_unpack;
    import cl_pkg::*;

    logic             clk = 1'b0;
    logic             rst_sync;
    logic             ff_rd_ready;
    logic [W_LEN-1:0] sb_len;
    logic             ff_rd_empty;
    logic [CL-1:0]    ff_rd_data;
    logic             ff_rd_ack;
    logic             ff_rd_finish;
    logic [ST_W-1:0]  source_st;
    logic             source_valid;
    logic             source_ready;
    logic             source_sop;
    logic             source_eop;
    logic [W_LEN-1:0] frm_len;
    logic             err_len;

    typedef struct {
        int nCl;
        int nst0;
        int nst1;
        int nst2;
        int sbLen;
        int toggle;
        int expCount;
        int errIfChk;
        int finLat;
        int fillDelay;
    } vector_t;

    vector_t        vecs[9];
    int             checks = 0;
    int             failures = 0;
    logic [CL-1:0]  fifoQ[$];
    logic [CL-1:0]  pendQ[$];
    logic [ST_W-1:0] expSt[$];

    always #5 clk = ~clk;

    cl_payload_unpack dut (
        .clk          (clk),
        .rst_sync     (rst_sync),
        .ff_rd_ready  (ff_rd_ready),
        .sb_len       (sb_len),
        .ff_rd_empty  (ff_rd_empty),
        .ff_rd_data   (ff_rd_data),
        .ff_rd_ack    (ff_rd_ack),
        .ff_rd_finish (ff_rd_finish),
        .source_st    (source_st),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .frm_len      (frm_len),
        .err_len      (err_len)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic refreshFifo();
        ff_rd_empty = (fifoQ.size() == 0);
        if (ff_rd_empty) ff_rd_data = '0;
        else ff_rd_data = fifoQ[0];
    endtask

    function automatic int nstOf(input vector_t v, input int c);
        if (c == 0) return v.nst0;
        if (c == 1) return v.nst1;
        return v.nst2;
    endfunction

    // Symbol k of CL c carries 0x1000*(c+1)+k so ordering errors are visible in the value.
    task automatic buildFrame(input vector_t v);
        logic [CL-1:0] cl;
        int nst;
        pendQ.delete();
        expSt.delete();
        for (int c = 0; c < v.nCl; c++) begin
            nst = nstOf(v, c);
            cl = '0;
            cl[EOF_BIT] = (c == v.nCl - 1);
            cl[NST_HI:NST_LO] = 12'(nst);
            for (int k = 0; k < ST_PER_CL; k++) begin
                cl[CL_PAYLOAD-1-k*ST_W -: ST_W] = 16'((c + 1) * 4096 + k);
            end
            pendQ.push_back(cl);
            for (int k = 0; k < nst && k < ST_PER_CL; k++) begin
                if (expSt.size() < v.sbLen) expSt.push_back(16'((c + 1) * 4096 + k));
            end
        end
    endtask

    task automatic fillFifo();
        foreach (pendQ[i]) fifoQ.push_back(pendQ[i]);
        pendQ.delete();
        refreshFifo();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " source_valid"}, int'(source_valid), 0);
        checkOutput({tag, " source_sop"}, int'(source_sop), 0);
        checkOutput({tag, " source_eop"}, int'(source_eop), 0);
        checkOutput({tag, " source_st"}, int'(source_st), 0);
        checkOutput({tag, " ff_rd_ack"}, int'(ff_rd_ack), 0);
        checkOutput({tag, " ff_rd_finish"}, int'(ff_rd_finish), 0);
        checkOutput({tag, " frm_len"}, int'(frm_len), 0);
        checkOutput({tag, " err_len"}, int'(err_len), 0);
    endtask

    task automatic applyStimulus(input vector_t v, input int id);
        int cyc = 0, got = 0, acks = 0, ackEmpty = 0, firstAck = -1, firstValid = -1;
        int lastAck = -1, lastHs = -1, finCyc = -1, stallViol = 0, errOutside = 0;
        int extraFin = 0, expErr, expAck;
        bit doPop, done = 1'b0, prevValid = 1'b0, prevReady = 1'b0, prevSop = 1'b0, prevEop = 1'b0;
        logic [ST_W-1:0] prevSt = '0;
        string tag;
        tag = $sformatf("v%0d", id);
`ifdef CL_UNPACK_LEN_CHK_EN
        expErr = v.errIfChk;
`else
        expErr = 0;
`endif
        expAck = (v.fillDelay == 0) ? 1 : v.fillDelay;
        buildFrame(v);
        if (v.fillDelay == 0) fillFifo();
        @(posedge clk); #1;
        sb_len = 16'(v.sbLen);
        ff_rd_ready = 1'b1;
        source_ready = 1'b1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            doPop = 1'b0;
            if (ff_rd_ack) begin
                acks++;
                if (ff_rd_empty) ackEmpty++;
                if (firstAck < 0) firstAck = cyc;
                lastAck = cyc;
                doPop = 1'b1;
            end
            if (prevValid && !prevReady && (!source_valid || source_st != prevSt ||
                source_sop != prevSop || source_eop != prevEop)) stallViol++;
            if (source_valid && firstValid < 0) firstValid = cyc;
            if (source_valid && source_ready) begin
                checkOutput($sformatf("%s st%0d data", tag, got), int'(source_st),
                            (got < expSt.size()) ? int'(expSt[got]) : -1);
                checkOutput($sformatf("%s st%0d sop", tag, got), int'(source_sop), int'(got == 0));
                checkOutput($sformatf("%s st%0d eop", tag, got), int'(source_eop), int'(got == v.sbLen - 1));
                got++;
                lastHs = cyc;
            end
            if (ff_rd_finish) begin
                finCyc = cyc;
                done = 1'b1;
                checkOutput({tag, " err_len at finish"}, int'(err_len), expErr);
                checkOutput({tag, " frm_len"}, int'(frm_len), v.sbLen);
            end else if (err_len) begin
                errOutside++;
            end
            prevValid = source_valid;
            prevReady = source_ready;
            prevSt = source_st;
            prevSop = source_sop;
            prevEop = source_eop;
            @(posedge clk); #1;
            if (doPop && fifoQ.size() > 0) fifoQ.delete(0);
            if (v.fillDelay > 0 && cyc == v.fillDelay - 1) fillFifo();
            refreshFifo();
            if (v.toggle != 0) source_ready = ~source_ready;
            if (done) ff_rd_ready = 1'b0;
            cyc++;
        end
        checkOutput({tag, " finished within budget"}, int'(done), 1);
        if (!done) begin
            ff_rd_ready = 1'b0;
            rst_sync = 1'b1;
            fifoQ.delete();
            refreshFifo();
            @(posedge clk); #1;
            rst_sync = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            if (ff_rd_finish || ff_rd_ack) extraFin++;
        end
        checkOutput({tag, " STs emitted"}, got, v.expCount);
        checkOutput({tag, " acks"}, acks, v.nCl);
        checkOutput({tag, " ack while empty"}, ackEmpty, 0);
        checkOutput({tag, " first ack cycle"}, firstAck, expAck);
        if (v.expCount > 0) checkOutput({tag, " first valid cycle"}, firstValid, expAck + 1);
        if (v.finLat == 1) checkOutput({tag, " finish after last ST"}, finCyc, lastHs + 1);
        else if (v.finLat == 2) checkOutput({tag, " finish after zero-count load"}, finCyc, lastAck + 1);
        if (v.toggle != 0) checkOutput({tag, " stable while stalled"}, stallViol, 0);
        checkOutput({tag, " err_len outside finish"}, errOutside, 0);
        checkOutput({tag, " no retrigger after finish"}, extraFin, 0);
    endtask

    initial begin
        int hs, n, lateFin;
        //          nCl nst0 nst1 nst2 sbLen tog exp err fin fill
        vecs[0] = '{1,  5,   0,   0,   5,    0,  5,  0,  1,  0};
        vecs[1] = '{3,  31,  31,  10,  72,   0,  72, 0,  1,  0};
        vecs[2] = '{3,  31,  31,  10,  72,   1,  72, 0,  1,  0};
        vecs[3] = '{2,  3,   3,   0,   4,    0,  4,  1,  0,  0};
        vecs[4] = '{1,  40,  0,   0,   31,   0,  31, 1,  1,  0};
        vecs[5] = '{2,  10,  0,   0,   10,   0,  10, 0,  2,  0};
        vecs[6] = '{1,  5,   0,   0,   0,    0,  0,  1,  0,  0};
        vecs[7] = '{1,  5,   0,   0,   8,    0,  5,  1,  1,  0};
        vecs[8] = '{1,  2,   0,   0,   2,    1,  2,  0,  1,  4};

        rst_sync = 1'b1;
        ff_rd_ready = 1'b0;
        sb_len = '0;
        source_ready = 1'b1;
        refreshFifo();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("in reset");
        @(posedge clk); #1;
        rst_sync = 1'b0;
        @(negedge clk);
        checkResetOutputs("after reset");

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

        // Interrupt a frame mid-EMIT with reset; upstream and its FIFO reset alongside.
        buildFrame(vecs[4]);
        fillFifo();
        @(posedge clk); #1;
        sb_len = 16'd31;
        ff_rd_ready = 1'b1;
        source_ready = 1'b1;
        hs = 0;
        n = 0;
        while (hs < 3 && n < 50) begin
            @(negedge clk);
            if (source_valid && source_ready) hs++;
            n++;
        end
        checkOutput("reset-seq reached EMIT", hs, 3);
        @(posedge clk); #1;
        rst_sync = 1'b1;
        ff_rd_ready = 1'b0;
        fifoQ.delete();
        refreshFifo();
        @(posedge clk); #1;
        rst_sync = 1'b0;
        @(negedge clk);
        checkResetOutputs("mid-frame reset");
        lateFin = 0;
        repeat (5) begin
            @(negedge clk);
            if (ff_rd_finish || source_valid) lateFin++;
        end
        checkOutput("no finish after mid-frame reset", lateFin, 0);

        applyStimulus(vecs[0], 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
